// File: rtl/mux_2to1_pipe.sv
// Registered 2:1 select stage with valid/ready handshake and a one-beat skid buffer.
// Optional per-select acceptance counters are enabled by defining MUX_SEL_COUNT_EN.
module mux_2to1_pipe #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_SEL_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b
`endif
);

  logic [WIDTH-1:0] d_p0;
  logic             accept;
  logic             main_free;
  logic [WIDTH-1:0] y_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] skid_p1;
  logic             skid_vld_p1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Stage p0: select is resolved at acceptance, so later input changes cannot leak in
  assign d_p0      = sel ? b : a;
  assign accept    = in_valid & in_ready;
  assign main_free = ~vld_p1 | out_ready;

  // Stage p1: output register, refilled from skid first to preserve order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1        <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (main_free) begin
      if (skid_vld_p1) begin
        y_p1        <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        y_p1   <= d_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !main_free) begin
      skid_p1 <= d_p0;
    end
  end

  // in_ready comes straight from the skid flag, keeping out_ready off the upstream path
  assign in_ready  = ~skid_vld_p1;
  assign y         = y_p1;
  assign out_valid = vld_p1;

`ifdef MUX_SEL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (accept) begin
      if (sel) begin
        cnt_b <= sat_inc(cnt_b);
      end else begin
        cnt_a <= sat_inc(cnt_a);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_2to1_pipe.sv
// Directed bench for mux_2to1_pipe with a queue scoreboard on the output stream.
module tb_mux_2to1_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, y;
  logic       sel, in_valid, in_ready, out_valid, out_ready;
`ifdef MUX_SEL_COUNT_EN
  logic [1:0] cnt_a, cnt_b;
`endif

  int         tests = 0;
  int         fails = 0;
  int         xfer_cnt = 0;
  logic [7:0] exp_q[$];

  mux_2to1_pipe #(.WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_COUNT_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] ai, input logic [7:0] bi, input logic si);
    a = ai; b = bi; sel = si; in_valid = 1'b1;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);
    tick();
    check("drain_idle", out_valid, 1'b0);
  endtask

  // Scoreboard: inputs are stable between the +1 drive point and the next edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("sb_order", y, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(sel ? b : a);
    end
  end

  logic [2:0] tt [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  logic       req[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int         base;

  initial begin
    rst_n = 1'b0; a = '0; b = '0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_y", y, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Truth table on bit 0, one beat per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat({7'b0, tt[i][2]}, {7'b0, tt[i][1]}, tt[i][0]);
      tick();
      check("tt_y", y, {7'b0, req[i]});
      check("tt_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    check("tt_idle", out_valid, 0);

    // Backpressure fills main then skid
    out_ready = 1'b0;
    beat(8'h11, 8'hEE, 1'b0);
    tick();
    check("bp_ready_after1", in_ready, 1);
    beat(8'hDD, 8'h22, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_ready_after2", in_ready, 0);
    check("bp_head", y, 8'h11);
    out_ready = 1'b1;
    tick();
    check("bp_second", y, 8'h22);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Full throughput
    base = xfer_cnt;
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), 8'(8'hF0 | i), i[0]);
      tick();
      check("tp_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("tp_beats", xfer_cnt - base, 16);
    check("tp_idle", out_valid, 0);

    // Asynchronous reset mid-stream with both registers full
    out_ready = 1'b0;
    beat(8'h33, 8'h00, 1'b0);
    tick();
    beat(8'h00, 8'h44, 1'b1);
    tick();
    in_valid = 1'b0;
    check("ar_full", in_ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_y", y, 0);
    check("ar_in_ready", in_ready, 1);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("ar_no_stale", out_valid, 0);
    check("ar_queue", exp_q.size(), 0);

    // Hold stability under backpressure, including X select while idle
    out_ready = 1'b0;
    beat(8'hA5, 8'h5A, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom);
      tick();
      check("hold_y", y, 8'hA5);
      check("hold_valid", out_valid, 1);
    end
    sel = 1'bx;
    tick();
    check("xsel_y", y, 8'hA5);
    check("xsel_ready", in_ready, 1);
    sel = 1'b0;
    drain();

`ifdef MUX_SEL_COUNT_EN
    rst_n = 1'b0;
    #1;
    check("cnt_rst_a", cnt_a, 0);
    check("cnt_rst_b", cnt_b, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      beat(8'(i), 8'(8'h80 | i), i == 5);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("cnt_a_sat", cnt_a, 3);
    check("cnt_b", cnt_b, 1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
